pu_wb_pipe5: RTL and testbench

- Stage 5 of the PU pipeline, directly downstream of the requant stage (pipe4).
- Accepts one output row for 4 output channels per beat (4 × PE_COL_NUM × REQUANT_WD bits).
- Serializes the beat into one write per channel onto the output-buffer write port and generates write addresses.
- Runs a tile of cfg_row_num rows per start_i and pulses done_o at the end.

---
 rtl/pu_pkg.sv | 25 ++
 rtl/pu_wb_addr_gen.sv | 85 ++++++++
 rtl/pu_wb_pipe5.sv | 158 +++++++++++++++
 tb/tb_pu_wb_pipe5.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pu_pkg
//  Description : Shared definitions for the PU write-back stage: FSM state
//                encoding, default address width and the channel-count
//                normalisation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pu_pkg;

  localparam int unsigned PU_ADDR_WD = 16;

  // Write-back FSM state encoding
  localparam int unsigned ST_WD = 2;
  localparam logic [ST_WD-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_WD-1:0] ST_WAIT_IN = 2'd1;
  localparam logic [ST_WD-1:0] ST_WRITE   = 2'd2;

  // Valid channels per beat are 1..4; anything outside that range means "all 4"
  function automatic logic [2:0] norm_oc_num(input logic [2:0] oc_num);
    return ((oc_num == 3'd0) || (oc_num > 3'd4)) ? 3'd4 : oc_num;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pu_wb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pu_wb_addr_gen
//  Description : Address generator for the write-back stage. Tracks the row
//                base, the current channel address and the row/channel
//                counters using adders only; all sums wrap at 2^ADDR_WD.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_wb_addr_gen
  import pu_pkg::*;
#(
  parameter int unsigned ADDR_WD    = PU_ADDR_WD,
  parameter int unsigned ROW_CNT_WD = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tile_start_i,
  input  logic [ADDR_WD-1:0]    base_addr_i,
  input  logic [ADDR_WD-1:0]    oc_stride_i,
  input  logic [ADDR_WD-1:0]    row_stride_i,
  input  logic [ROW_CNT_WD-1:0] row_last_i,
  input  logic [1:0]            oc_last_i,
  input  logic                  load_i,
  input  logic                  step_oc_i,
  input  logic                  step_row_i,
  output logic [ADDR_WD-1:0]    cur_addr_o,
  output logic [1:0]            oc_cnt_o,
  output logic                  last_oc_o,
  output logic                  last_row_o
);

  logic [ADDR_WD-1:0]    row_base_q, row_base_d;
  logic [ADDR_WD-1:0]    cur_addr_q, cur_addr_d;
  logic [ROW_CNT_WD-1:0] row_cnt_q, row_cnt_d;
  logic [1:0]            oc_cnt_q, oc_cnt_d;
  logic [ADDR_WD-1:0]    next_row_base;

  assign next_row_base = row_base_q + row_stride_i;

  // Next-state for counters; a load coinciding with a row step starts the new row directly
  always_comb begin
    row_base_d = row_base_q;
    cur_addr_d = cur_addr_q;
    row_cnt_d  = row_cnt_q;
    oc_cnt_d   = oc_cnt_q;
    if (tile_start_i) begin
      row_base_d = base_addr_i;
      row_cnt_d  = '0;
      oc_cnt_d   = 2'd0;
    end
    if (step_row_i) begin
      row_base_d = next_row_base;
      row_cnt_d  = row_cnt_q + ROW_CNT_WD'(1);
    end
    if (load_i) begin
      oc_cnt_d   = 2'd0;
      cur_addr_d = step_row_i ? next_row_base : row_base_q;
    end else if (step_oc_i) begin
      oc_cnt_d   = oc_cnt_q + 2'd1;
      cur_addr_d = cur_addr_q + oc_stride_i;
    end
  end

  // Counter and address registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_base_q <= '0;
      cur_addr_q <= '0;
      row_cnt_q  <= '0;
      oc_cnt_q   <= 2'd0;
    end else begin
      row_base_q <= row_base_d;
      cur_addr_q <= cur_addr_d;
      row_cnt_q  <= row_cnt_d;
      oc_cnt_q   <= oc_cnt_d;
    end
  end

  assign cur_addr_o = cur_addr_q;
  assign oc_cnt_o   = oc_cnt_q;
  assign last_oc_o  = (oc_cnt_q == oc_last_i);
  assign last_row_o = (row_cnt_q == row_last_i);

endmodule
`default_nettype wire

// File: rtl/pu_wb_pipe5.sv
`default_nettype none
// ============================================================================
//  Module      : pu_wb_pipe5
//  Description : PU pipeline stage 5 (write-back). Accepts one 4-channel row
//                beat from requant, serialises it into one output-buffer
//                write per valid channel, and pulses done_o after the last
//                write of a tile.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_wb_pipe5
  import pu_pkg::*;
#(
  parameter int unsigned PE_COL_NUM = 32,
  parameter int unsigned REQUANT_WD = 8,
  parameter int unsigned ADDR_WD    = PU_ADDR_WD,
  parameter int unsigned ROW_CNT_WD = 10
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start_i,
  input  logic [ADDR_WD-1:0]                 cfg_base_addr_i,
  input  logic [ADDR_WD-1:0]                 cfg_oc_stride_i,
  input  logic [ADDR_WD-1:0]                 cfg_row_stride_i,
  input  logic [ROW_CNT_WD-1:0]              cfg_row_num_i,
  input  logic [2:0]                         cfg_oc_num_i,
  input  logic                               wb_vld_i,
  output logic                               wb_rdy_o,
  input  logic [REQUANT_WD*PE_COL_NUM-1:0]   wb_oc0_i,
  input  logic [REQUANT_WD*PE_COL_NUM-1:0]   wb_oc1_i,
  input  logic [REQUANT_WD*PE_COL_NUM-1:0]   wb_oc2_i,
  input  logic [REQUANT_WD*PE_COL_NUM-1:0]   wb_oc3_i,
  output logic                               wr_vld_o,
  input  logic                               wr_rdy_i,
  output logic [ADDR_WD-1:0]                 wr_addr_o,
  output logic [REQUANT_WD*PE_COL_NUM-1:0]   wr_data_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int unsigned DATA_WD = REQUANT_WD * PE_COL_NUM;

  logic [ST_WD-1:0]      state_q, state_d;
  logic [ADDR_WD-1:0]    oc_stride_q, row_stride_q;
  logic [ROW_CNT_WD-1:0] row_last_q;
  logic [1:0]            oc_last_q;
  logic [DATA_WD-1:0]    row_q [4];
  logic                  done_q;

  logic                  tile_start, accept, fire, step_oc, step_row;
  logic                  last_oc, last_row;
  logic [1:0]            oc_cnt;
  logic [ADDR_WD-1:0]    cur_addr;
  logic [2:0]            oc_num_norm;

  assign oc_num_norm = norm_oc_num(cfg_oc_num_i);
  assign tile_start  = (state_q == ST_IDLE) && start_i;
  assign fire        = (state_q == ST_WRITE) && wr_rdy_i;
  assign accept      = wb_vld_i && wb_rdy_o;
  assign step_oc     = fire && !last_oc;
  assign step_row    = fire && last_oc && !last_row;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a waiting beat at row end keeps the stage in WRITE with no bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_WAIT_IN;
      ST_WAIT_IN: if (accept)  state_d = ST_WRITE;
      ST_WRITE: begin
        if (fire && last_oc) begin
          if (last_row)      state_d = ST_IDLE;
          else if (wb_vld_i) state_d = ST_WRITE;
          else               state_d = ST_WAIT_IN;
        end
      end
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output decode; upstream ready in WRITE only on the final write of a non-final row
  always_comb begin
    wb_rdy_o  = 1'b0;
    wr_vld_o  = 1'b0;
    wr_addr_o = '0;
    busy_o    = (state_q != ST_IDLE);
    case (state_q)
      ST_WAIT_IN: wb_rdy_o = 1'b1;
      ST_WRITE: begin
        wr_vld_o  = 1'b1;
        wr_addr_o = cur_addr;
        wb_rdy_o  = fire && last_oc && !last_row;
      end
      default: ;
    endcase
  end

  // Tile configuration snapshot taken at start; row/channel counts stored as last index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      oc_stride_q  <= '0;
      row_stride_q <= '0;
      row_last_q   <= '0;
      oc_last_q    <= 2'd0;
    end else if (tile_start) begin
      oc_stride_q  <= cfg_oc_stride_i;
      row_stride_q <= cfg_row_stride_i;
      row_last_q   <= (cfg_row_num_i == '0) ? '0 : (cfg_row_num_i - ROW_CNT_WD'(1));
      oc_last_q    <= 2'(oc_num_norm - 3'd1);
    end
  end

  // Beat capture; data registers carry no reset since they are qualified by wr_vld_o
  always_ff @(posedge clk) begin
    if (accept) begin
      row_q[0] <= wb_oc0_i;
      row_q[1] <= wb_oc1_i;
      row_q[2] <= wb_oc2_i;
      row_q[3] <= wb_oc3_i;
    end
  end

  // Done pulse one cycle after the last write of the tile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) done_q <= 1'b0;
    else       done_q <= fire && last_oc && last_row;
  end

  assign wr_data_o = row_q[oc_cnt];
  assign done_o    = done_q;

  pu_wb_addr_gen #(
    .ADDR_WD    (ADDR_WD),
    .ROW_CNT_WD (ROW_CNT_WD)
  ) u_addr_gen (
    .clk          (clk),
    .rstn         (rstn),
    .tile_start_i (tile_start),
    .base_addr_i  (cfg_base_addr_i),
    .oc_stride_i  (oc_stride_q),
    .row_stride_i (row_stride_q),
    .row_last_i   (row_last_q),
    .oc_last_i    (oc_last_q),
    .load_i       (accept),
    .step_oc_i    (step_oc),
    .step_row_i   (step_row),
    .cur_addr_o   (cur_addr),
    .oc_cnt_o     (oc_cnt),
    .last_oc_o    (last_oc),
    .last_row_o   (last_row)
  );

endmodule
`default_nettype wire

// File: tb/tb_pu_wb_pipe5.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pu_wb_pipe5
//  Description : Self-checking bench for pu_wb_pipe5 with a queue-based
//                reference model of the expected write stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_wb_pipe5;

  localparam int PE  = 32;
  localparam int RW  = 8;
  localparam int AW  = 16;
  localparam int RCW = 10;
  localparam int DW  = PE * RW;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start_i;
  logic [AW-1:0]  cfg_base_addr_i, cfg_oc_stride_i, cfg_row_stride_i;
  logic [RCW-1:0] cfg_row_num_i;
  logic [2:0]     cfg_oc_num_i;
  logic           wb_vld_i, wb_rdy_o;
  logic [DW-1:0]  wb_oc0_i, wb_oc1_i, wb_oc2_i, wb_oc3_i;
  logic           wr_vld_o, wr_rdy_i;
  logic [AW-1:0]  wr_addr_o;
  logic [DW-1:0]  wr_data_o;
  logic           busy_o, done_o;

  always #5 clk = ~clk;

  pu_wb_pipe5 #(
    .PE_COL_NUM (PE),
    .REQUANT_WD (RW),
    .ADDR_WD    (AW),
    .ROW_CNT_WD (RCW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start_i          (start_i),
    .cfg_base_addr_i  (cfg_base_addr_i),
    .cfg_oc_stride_i  (cfg_oc_stride_i),
    .cfg_row_stride_i (cfg_row_stride_i),
    .cfg_row_num_i    (cfg_row_num_i),
    .cfg_oc_num_i     (cfg_oc_num_i),
    .wb_vld_i         (wb_vld_i),
    .wb_rdy_o         (wb_rdy_o),
    .wb_oc0_i         (wb_oc0_i),
    .wb_oc1_i         (wb_oc1_i),
    .wb_oc2_i         (wb_oc2_i),
    .wb_oc3_i         (wb_oc3_i),
    .wr_vld_o         (wr_vld_o),
    .wr_rdy_i         (wr_rdy_i),
    .wr_addr_o        (wr_addr_o),
    .wr_data_o        (wr_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            row_end;
    bit            last;
  } wr_t;

  wr_t           exp_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  int            feed_cnt = 0;
  int            feed_ptr = 0;
  bit            done_exp = 1'b0;
  logic [AW-1:0] ob_addr[$];
  int            ob_cyc[$];
  int            acc_cyc[$];
  int            done_cyc[$];

  // Distinct payload per (beat id, channel)
  function automatic logic [DW-1:0] mk(int id, int oc);
    logic [DW-1:0] v;
    for (int k = 0; k < PE; k++) v[k*RW +: RW] = 8'((id * 37 + oc * 11 + k * 3) & 255);
    return v;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream source: presents beats feed_ptr..feed_cnt-1 in order
  initial begin : feeder
    bit acc;
    wb_vld_i = 1'b0;
    wb_oc0_i = '0; wb_oc1_i = '0; wb_oc2_i = '0; wb_oc3_i = '0;
    forever begin
      @(negedge clk);
      acc = rstn && wb_vld_i && wb_rdy_o;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      if (acc) feed_ptr++;
      if (feed_ptr < feed_cnt) begin
        wb_vld_i = 1'b1;
        wb_oc0_i = mk(feed_ptr, 0);
        wb_oc1_i = mk(feed_ptr, 1);
        wb_oc2_i = mk(feed_ptr, 2);
        wb_oc3_i = mk(feed_ptr, 3);
      end else begin
        wb_vld_i = 1'b0;
      end
    end
  end

  // Compare process: write stream, done pulse, upstream ready and hold-under-backpressure
  initial begin : compare
    wr_t           e;
    bit            hold_prev;
    bit            exp_rdy;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    hold_prev = 1'b0;
    p_addr = '0;
    p_data = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("done_o", DW'(done_o), DW'(done_exp));
        done_exp = 1'b0;
        exp_rdy = (busy_o && !wr_vld_o) ||
                  (wr_vld_o && wr_rdy_i && exp_q.size() > 0 && exp_q[0].row_end && !exp_q[0].last);
        chk("wb_rdy_o", DW'(wb_rdy_o), DW'(exp_rdy));
        if (hold_prev) begin
          chk("hold_vld", DW'(wr_vld_o), DW'(1'b1));
          chk("hold_addr", DW'(wr_addr_o), DW'(p_addr));
          chk("hold_data", wr_data_o, p_data);
        end
        hold_prev = wr_vld_o && !wr_rdy_i;
        p_addr = wr_addr_o;
        p_data = wr_data_o;
        if (wr_vld_o && wr_rdy_i) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h, expected no write", wr_addr_o);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", DW'(wr_addr_o), DW'(e.addr));
            chk("wr_data", wr_data_o, e.data);
            if (e.last) done_exp = 1'b1;
            ob_addr.push_back(wr_addr_o);
            ob_cyc.push_back(cyc);
          end
        end
        if (done_o) done_cyc.push_back(cyc);
      end else begin
        hold_prev = 1'b0;
        done_exp  = 1'b0;
      end
    end
  end

  task automatic clear_logs();
    ob_addr.delete();
    ob_cyc.delete();
    acc_cyc.delete();
    done_cyc.delete();
  endtask

  // Push the expected write stream for a tile, then pulse start with that config
  task automatic start_tile(logic [AW-1:0] b, logic [AW-1:0] os, logic [AW-1:0] rs,
                            logic [RCW-1:0] rn, logic [2:0] on);
    int  rows;
    int  ocn;
    wr_t e;
    rows = (rn == 0) ? 1 : int'(rn);
    ocn  = (on == 0 || on > 4) ? 4 : int'(on);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < ocn; c++) begin
        e.addr    = AW'(int'(b) + r * int'(rs) + c * int'(os));
        e.data    = mk(feed_cnt + r, c);
        e.row_end = (c == ocn - 1);
        e.last    = (c == ocn - 1) && (r == rows - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cfg_base_addr_i  = b;
    cfg_oc_stride_i  = os;
    cfg_row_stride_i = rs;
    cfg_row_num_i    = rn;
    cfg_oc_num_i     = on;
    start_i          = 1'b1;
    feed_cnt         = feed_cnt + rows;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", DW'(seen), DW'(1'b1));
    chk("model_drained", DW'(exp_q.size()), DW'(0));
    chk("beats_consumed", DW'(feed_ptr), DW'(feed_cnt));
    @(negedge clk);
  endtask

  task automatic wait_writes(int n, int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ob_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("writes_reached", DW'(ok), DW'(1'b1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    rstn = 1'b0;
    start_i = 1'b0;
    wr_rdy_i = 1'b1;
    cfg_base_addr_i = '0; cfg_oc_stride_i = '0; cfg_row_stride_i = '0;
    cfg_row_num_i = '0; cfg_oc_num_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_vld", DW'(wr_vld_o), DW'(1'b0));
    chk("rst_wb_rdy", DW'(wb_rdy_o), DW'(1'b0));
    chk("rst_busy", DW'(busy_o), DW'(1'b0));
    chk("rst_done", DW'(done_o), DW'(1'b0));
    chk("rst_addr", DW'(wr_addr_o), DW'(0));
    #2 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Basic tile, two back-to-back beats
    clear_logs();
    start_tile(16'h0100, 16'h0040, 16'h0004, 10'd2, 3'd4);
    wait_done(60);
    chk("basic_n", DW'(ob_addr.size()), DW'(8));
    chk("basic_a0", DW'(ob_addr[0]), DW'(16'h0100));
    chk("basic_a3", DW'(ob_addr[3]), DW'(16'h01C0));
    chk("basic_a4", DW'(ob_addr[4]), DW'(16'h0104));
    chk("basic_a7", DW'(ob_addr[7]), DW'(16'h01C4));
    chk("basic_latency", DW'(ob_cyc[0]), DW'(acc_cyc[0] + 1));
    chk("basic_nobubble", DW'(acc_cyc[1]), DW'(ob_cyc[3]));
    chk("basic_done_cyc", DW'(done_cyc[0]), DW'(ob_cyc[7] + 1));

    // Partial channels
    clear_logs();
    start_tile(16'h0200, 16'h0010, 16'h0020, 10'd3, 3'd2);
    wait_done(60);
    chk("partial_n", DW'(ob_addr.size()), DW'(6));
    chk("partial_a5", DW'(ob_addr[5]), DW'(16'h0250));
    chk("partial_rdy_period", DW'(acc_cyc[2] - acc_cyc[1]), DW'(2));

    // Backpressure on the second write
    clear_logs();
    start_tile(16'h0300, 16'h0008, 16'h0100, 10'd2, 3'd4);
    wait_writes(1, 40);
    @(posedge clk);
    #1 wr_rdy_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 wr_rdy_i = 1'b1;
    wait_done(60);
    chk("bp_n", DW'(ob_addr.size()), DW'(8));
    chk("bp_stall", DW'(ob_cyc[1] - ob_cyc[0]), DW'(6));
    chk("bp_a1", DW'(ob_addr[1]), DW'(16'h0308));

    // Address wrap, oc_num=0 and row_num=0 normalisation
    clear_logs();
    start_tile(16'hFFF0, 16'h0010, 16'h1000, 10'd0, 3'd0);
    wait_done(40);
    chk("wrap_n", DW'(ob_addr.size()), DW'(4));
    chk("wrap_a0", DW'(ob_addr[0]), DW'(16'hFFF0));
    chk("wrap_a1", DW'(ob_addr[1]), DW'(16'h0000));
    chk("wrap_a2", DW'(ob_addr[2]), DW'(16'h0010));
    chk("wrap_a3", DW'(ob_addr[3]), DW'(16'h0020));

    // Start and config changes mid-tile are ignored; oc_num=7 means 4
    clear_logs();
    start_tile(16'h0400, 16'h0004, 16'h0040, 10'd2, 3'd3);
    wait_writes(1, 40);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    cfg_base_addr_i = 16'h9999; cfg_oc_stride_i = 16'h0777;
    cfg_row_stride_i = 16'h0555; cfg_row_num_i = 10'd7; cfg_oc_num_i = 3'd1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(60);
    chk("ign_n", DW'(ob_addr.size()), DW'(6));
    chk("ign_a4", DW'(ob_addr[4]), DW'(16'h0444));
    clear_logs();
    start_tile(16'h0500, 16'h0002, 16'h0030, 10'd1, 3'd7);
    wait_done(40);
    chk("restart_n", DW'(ob_addr.size()), DW'(4));
    chk("restart_a3", DW'(ob_addr[3]), DW'(16'h0506));

    // Reset in the middle of a tile
    clear_logs();
    start_tile(16'h0600, 16'h0010, 16'h0080, 10'd3, 3'd4);
    wait_writes(2, 40);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_wr_vld", DW'(wr_vld_o), DW'(1'b0));
    chk("mrst_busy", DW'(busy_o), DW'(1'b0));
    chk("mrst_wb_rdy", DW'(wb_rdy_o), DW'(1'b0));
    chk("mrst_addr", DW'(wr_addr_o), DW'(0));
    chk("mrst_done", DW'(done_o), DW'(1'b0));
    exp_q.delete();
    feed_ptr = feed_cnt;
    done_exp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst_idle", DW'(busy_o), DW'(1'b0));
    clear_logs();
    start_tile(16'h0700, 16'h0020, 16'h0008, 10'd1, 3'd2);
    wait_done(40);
    chk("post_rst_n", DW'(ob_addr.size()), DW'(2));
    chk("post_rst_a0", DW'(ob_addr[0]), DW'(16'h0700));
    chk("post_rst_a1", DW'(ob_addr[1]), DW'(16'h0720));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
